// File: rtl/rng_arbiter.sv
// Two-requester round-robin front end for an external 8-bit LFSR shifter.
// Each grant advances the shifter STEPS times and delivers the resulting byte.
module rng_arbiter #(
  parameter int unsigned STEPS        = 8,
  parameter logic [7:0]  DEFAULT_SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] seed,
  input  logic       seed_load,
  input  logic [1:0] req,
  input  logic [7:0] q,
  output logic       sh_load_n,
  output logic       sh_shift,
  output logic [7:0] sh_load_val,
  output logic [1:0] gnt,
  output logic       valid,
  output logic [7:0] rnd,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SEED, SHIFT, DONE} state_t;

  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  state_t     state_q, state_d;
  logic [7:0] seed_q;
  logic [3:0] cnt_q;
  logic       sel_q, sel_d;
  logic       prio_q;
  logic [1:0] gnt_q;
  logic       valid_q;
  logic [7:0] rnd_q;
  logic       last_step;
  logic [7:0] q_next;

  // An all-zero LFSR state never leaves zero, so it is never allowed in.
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  assign last_step = (cnt_q == LAST_STEP);
  // The value q takes at the edge ending the final SHIFT cycle.
  assign q_next    = {q[6] ^ q[5] ^ q[4] ^ q[0], q[7:1]};

  always_comb begin
    sel_d = prio_q;
    case (req)
      2'b01:   sel_d = 1'b0;
      2'b10:   sel_d = 1'b1;
      default: sel_d = prio_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= SEED;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (seed_load)  state_d = SEED;
        else if (|req)  state_d = SHIFT;
      end
      SEED:    state_d = IDLE;
      SHIFT:   if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sh_load_n   = (state_q != SEED);
    sh_shift    = (state_q == SHIFT);
    sh_load_val = seed_q;
    busy        = (state_q != IDLE);
    gnt         = gnt_q;
    valid       = valid_q;
    rnd         = rnd_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      seed_q  <= fix_seed(DEFAULT_SEED);
      cnt_q   <= 4'd0;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      gnt_q   <= 2'b00;
      valid_q <= 1'b0;
      rnd_q   <= 8'h00;
    end else begin
      gnt_q   <= 2'b00;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (seed_load) begin
            seed_q <= fix_seed(seed);
          end else if (|req) begin
            sel_q <= sel_d;
            cnt_q <= 4'd0;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q + 4'd1;
          // Outputs register here so they line up with the DONE cycle.
          if (last_step) begin
            gnt_q   <= sel_q ? 2'b10 : 2'b01;
            valid_q <= 1'b1;
            rnd_q   <= q_next;
            prio_q  <= ~sel_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed bench for rng_arbiter: one STEPS=8 instance and one STEPS=1 instance,
// each driving a behavioural LFSR shifter that clears to 8'h00 in reset.
module tb_rng_arbiter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] seed = 8'h00, q;
  logic       seed_load = 1'b0;
  logic [1:0] req = 2'b00, gnt;
  logic       sh_load_n, sh_shift, valid, busy;
  logic [7:0] sh_load_val, rnd;

  logic [7:0] seed1 = 8'h00, q1;
  logic       seed_load1 = 1'b0;
  logic [1:0] req1 = 2'b00, gnt1;
  logic       sh_load_n1, sh_shift1, valid1, busy1;
  logic [7:0] sh_load_val1, rnd1;

  int nvec = 0;
  int nerr = 0;

  rng_arbiter #(.STEPS(8), .DEFAULT_SEED(8'hA5)) u0 (
    .clock(clock), .reset_n(reset_n), .seed(seed), .seed_load(seed_load),
    .req(req), .q(q), .sh_load_n(sh_load_n), .sh_shift(sh_shift),
    .sh_load_val(sh_load_val), .gnt(gnt), .valid(valid), .rnd(rnd), .busy(busy));

  rng_arbiter #(.STEPS(1), .DEFAULT_SEED(8'hA5)) u1 (
    .clock(clock), .reset_n(reset_n), .seed(seed1), .seed_load(seed_load1),
    .req(req1), .q(q1), .sh_load_n(sh_load_n1), .sh_shift(sh_shift1),
    .sh_load_val(sh_load_val1), .gnt(gnt1), .valid(valid1), .rnd(rnd1), .busy(busy1));

  always @(posedge clock) begin
    if (!reset_n)       q <= 8'h00;
    else if (!sh_load_n) q <= sh_load_val;
    else if (sh_shift)  q <= {q[6] ^ q[5] ^ q[4] ^ q[0], q[7:1]};
  end

  always @(posedge clock) begin
    if (!reset_n)        q1 <= 8'h00;
    else if (!sh_load_n1) q1 <= sh_load_val1;
    else if (sh_shift1)  q1 <= {q1[6] ^ q1[5] ^ q1[4] ^ q1[0], q1[7:1]};
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    nvec++; if (gnt !== 2'b00)   begin nerr++; $display("FAIL rst_gnt: got %b want 00", gnt); end
    nvec++; if (valid !== 1'b0)  begin nerr++; $display("FAIL rst_valid: got %b want 0", valid); end
    nvec++; if (rnd !== 8'h00)   begin nerr++; $display("FAIL rst_rnd: got %h want 00", rnd); end
    nvec++; if (busy !== 1'b1)   begin nerr++; $display("FAIL rst_busy: got %b want 1", busy); end
    reset_n = 1'b1;
    nvec++; if (sh_load_n !== 1'b0 || sh_load_val !== 8'hA5)
      begin nerr++; $display("FAIL rst_seed_cycle: got load_n=%b val=%h want 0/a5", sh_load_n, sh_load_val); end
    tick();
    nvec++; if (q !== 8'hA5)     begin nerr++; $display("FAIL rst_q: got %h want a5", q); end
    nvec++; if (sh_load_n !== 1'b1 || busy !== 1'b0)
      begin nerr++; $display("FAIL rst_idle: got load_n=%b busy=%b want 1/0", sh_load_n, busy); end
    tick();
    tick();
    nvec++; if (q !== 8'hA5 || gnt !== 2'b00 || valid !== 1'b0)
      begin nerr++; $display("FAIL rst_quiet: got q=%h gnt=%b valid=%b want a5/00/0", q, gnt, valid); end
    $display("test_reset: q=%h busy=%b", q, busy);
  endtask

  task automatic test_single_grant();
    int cyc = 1;
    req = 2'b01;
    tick();
    nvec++; if (sh_shift !== 1'b1 || sh_load_n !== 1'b1 || busy !== 1'b1)
      begin nerr++; $display("FAIL single_shift: got shift=%b load_n=%b busy=%b want 1/1/1", sh_shift, sh_load_n, busy); end
    while (valid !== 1'b1 && cyc < 30) begin tick(); cyc++; end
    nvec++; if (cyc != 9) begin nerr++; $display("FAIL single_latency: got %0d want 9", cyc); end
    nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL single_gnt: got %b want 01", gnt); end
    nvec++; if (rnd !== 8'h48) begin nerr++; $display("FAIL single_rnd: got %h want 48", rnd); end
    req = 2'b00;
    tick();
    nvec++; if (valid !== 1'b0 || gnt !== 2'b00 || rnd !== 8'h48 || busy !== 1'b0)
      begin nerr++; $display("FAIL single_after: got valid=%b gnt=%b rnd=%h busy=%b want 0/00/48/0", valid, gnt, rnd, busy); end
    $display("test_single_grant: latency=%0d rnd=%h", cyc, rnd);
  endtask

  task automatic test_contention();
    int t = 0;
    int last = 0;
    logic [1:0] want;
    apply_reset();
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      logic found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        tick();
        t++;
        if (gnt !== 2'b00) found = 1'b1;
      end
      want = (g % 2 == 0) ? 2'b01 : 2'b10;
      nvec++; if (gnt !== want) begin nerr++; $display("FAIL contend_gnt%0d: got %b want %b", g, gnt, want); end
      nvec++; if ((t - last) != ((g == 0) ? 9 : 10))
        begin nerr++; $display("FAIL contend_gap%0d: got %0d want %0d", g, t - last, (g == 0) ? 9 : 10); end
      $display("test_contention: grant %0d gnt=%b at cycle %0d", g, gnt, t);
      last = t;
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_zero_seed();
    int cyc = 1;
    seed1 = 8'h00;
    seed_load1 = 1'b1;
    tick();
    seed_load1 = 1'b0;
    nvec++; if (sh_load_n1 !== 1'b0 || sh_load_val1 !== 8'h01)
      begin nerr++; $display("FAIL zero_seed_load: got load_n=%b val=%h want 0/01", sh_load_n1, sh_load_val1); end
    tick();
    nvec++; if (q1 !== 8'h01) begin nerr++; $display("FAIL zero_seed_q: got %h want 01", q1); end
    req1 = 2'b01;
    tick();
    while (valid1 !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    req1 = 2'b00;
    nvec++; if (cyc != 2) begin nerr++; $display("FAIL zero_seed_latency: got %0d want 2", cyc); end
    nvec++; if (rnd1 !== 8'h80 || gnt1 !== 2'b01)
      begin nerr++; $display("FAIL zero_seed_rnd: got rnd=%h gnt=%b want 80/01", rnd1, gnt1); end
    $display("test_zero_seed: q1 seeded 01, rnd1=%h", rnd1);
    tick();
  endtask

  task automatic test_seed_priority();
    int cyc = 1;
    seed = 8'h3C;
    seed_load = 1'b1;
    req = 2'b10;
    tick();
    seed_load = 1'b0;
    nvec++; if (sh_load_n !== 1'b0 || sh_load_val !== 8'h3C || sh_shift !== 1'b0)
      begin nerr++; $display("FAIL prio_seed_first: got load_n=%b val=%h shift=%b want 0/3c/0", sh_load_n, sh_load_val, sh_shift); end
    tick();
    nvec++; if (q !== 8'h3C || busy !== 1'b0)
      begin nerr++; $display("FAIL prio_seeded: got q=%h busy=%b want 3c/0", q, busy); end
    tick();
    seed = 8'hFF;
    seed_load = 1'b1;
    nvec++; if (sh_shift !== 1'b1) begin nerr++; $display("FAIL prio_shifting: got %b want 1", sh_shift); end
    tick();
    cyc++;
    seed_load = 1'b0;
    nvec++; if (sh_load_n !== 1'b1) begin nerr++; $display("FAIL prio_ignore_load: got %b want 1", sh_load_n); end
    while (valid !== 1'b1 && cyc < 30) begin tick(); cyc++; end
    req = 2'b00;
    nvec++; if (cyc != 9) begin nerr++; $display("FAIL prio_latency: got %0d want 9", cyc); end
    nvec++; if (gnt !== 2'b10 || rnd !== 8'h36)
      begin nerr++; $display("FAIL prio_rnd: got gnt=%b rnd=%h want 10/36", gnt, rnd); end
    tick();
    tick();
    nvec++; if (busy !== 1'b0 || sh_load_n !== 1'b1)
      begin nerr++; $display("FAIL prio_not_queued: got busy=%b load_n=%b want 0/1", busy, sh_load_n); end
    $display("test_seed_priority: gnt=10 rnd=%h", rnd);
  endtask

  task automatic test_reset_mid_shift();
    int ngnt = 0;
    req = 2'b01;
    tick();
    tick();
    tick();
    req = 2'b00;
    reset_n = 1'b0;
    tick();
    nvec++; if (gnt !== 2'b00 || valid !== 1'b0 || rnd !== 8'h00 || sh_shift !== 1'b0)
      begin nerr++; $display("FAIL midrst_outputs: got gnt=%b valid=%b rnd=%h shift=%b want 00/0/00/0", gnt, valid, rnd, sh_shift); end
    tick();
    reset_n = 1'b1;
    tick();
    nvec++; if (q !== 8'hA5 || busy !== 1'b0)
      begin nerr++; $display("FAIL midrst_reload: got q=%h busy=%b want a5/0", q, busy); end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (gnt !== 2'b00 || valid !== 1'b0) ngnt++;
    end
    nvec++; if (ngnt != 0) begin nerr++; $display("FAIL midrst_no_grant: got %0d grant cycles want 0", ngnt); end
    $display("test_reset_mid_shift: q=%h rnd=%h", q, rnd);
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_contention();
    test_zero_seed();
    test_seed_priority();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
